// File: rtl/ddos_pkg.sv
// ddos_pkg: shared definitions for the DDoS per-flow counter controller.
//   - default entry width, RAM address width and window length
//   - FSM state encoding used by ddos_counter_ctrl
package ddos_pkg;

  localparam int DEF_BRAM_WIDTH     = 37;
  localparam int DEF_MAX_DEPTH_BITS = 14;
  localparam int DEF_WINDOW_CYCLES  = 125000000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    U_RD   = 3'd1,
    U_MOD  = 3'd2,
    U_WR   = 3'd3,
    H_RD   = 3'd4,
    H_WAIT = 3'd5,
    CLR    = 3'd6
  } ddos_state_e;

endpackage

// File: rtl/ddos_window_timer.sv
// ddos_window_timer: measurement-window counter and clear request flag.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   sw_clear_i        software pulse requesting an immediate table clear
//   clear_busy_i      high while the controller is sweeping the table
//   clr_start_i       controller is leaving IDLE for the sweep this cycle
//   clear_pending_o   a sweep is owed; set out of reset
module ddos_window_timer
  import ddos_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_clear_i,
  input  logic clear_busy_i,
  input  logic clr_start_i,
  output logic clear_pending_o
);

  localparam int CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             window_end;

  assign window_end = (cnt_q == LAST_CNT);

  always_comb begin
    // Held at zero during a sweep so the next window starts when it ends.
    if (clear_busy_i || window_end) cnt_d = '0;
    else                            cnt_d = cnt_q + CNT_W'(1);

    pend_d = pend_q;
    if (clr_start_i)
      pend_d = 1'b0;
    else if (!clear_busy_i && (sw_clear_i || window_end))
      pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign clear_pending_o = pend_q;

endmodule

// File: rtl/ddos_counter_ctrl.sv
// ddos_counter_ctrl: arbiter/sequencer for a single-port per-flow counter RAM
// (1-cycle registered read, read-during-write returns old data).
// Serialises packet increments (read-modify-write, saturating), host reads
// and whole-table clears; pulses an alarm when an entry first reaches the
// threshold.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   upd_valid/upd_idx/upd_ready      increment request handshake
//   host_rd_req/host_rd_idx          host read request (level until ack)
//   host_rd_ack/host_rd_data         1-cycle ack with read data (data held)
//   sw_clear                         request immediate table clear
//   threshold                        alarm threshold
//   alarm_valid/alarm_idx            threshold crossing pulse
//   clear_busy                       sweep in progress
//   bram_wr_en/bram_addr/bram_wr_data/bram_rd_data   RAM port
// Optional: define DDOS_CTRL_STATS_EN to add stat_upd_cnt, stat_alarm_cnt
// and stat_sat_cnt wrapping statistics counters.
module ddos_counter_ctrl
  import ddos_pkg::*;
#(
  parameter int BRAM_WIDTH     = DEF_BRAM_WIDTH,
  parameter int MAX_DEPTH_BITS = DEF_MAX_DEPTH_BITS,
  parameter int TOTAL_NUM      = 2**MAX_DEPTH_BITS,
  parameter int WINDOW_CYCLES  = DEF_WINDOW_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      upd_valid,
  input  logic [MAX_DEPTH_BITS-1:0] upd_idx,
  output logic                      upd_ready,
  input  logic                      host_rd_req,
  input  logic [MAX_DEPTH_BITS-1:0] host_rd_idx,
  output logic                      host_rd_ack,
  output logic [BRAM_WIDTH-1:0]     host_rd_data,
  input  logic                      sw_clear,
  input  logic [BRAM_WIDTH-1:0]     threshold,
  output logic                      alarm_valid,
  output logic [MAX_DEPTH_BITS-1:0] alarm_idx,
  output logic                      clear_busy,
`ifdef DDOS_CTRL_STATS_EN
  output logic [31:0]               stat_upd_cnt,
  output logic [31:0]               stat_alarm_cnt,
  output logic [31:0]               stat_sat_cnt,
`endif
  output logic                      bram_wr_en,
  output logic [MAX_DEPTH_BITS-1:0] bram_addr,
  output logic [BRAM_WIDTH-1:0]     bram_wr_data,
  input  logic [BRAM_WIDTH-1:0]     bram_rd_data
);

  localparam logic [MAX_DEPTH_BITS-1:0] LAST_ADDR = MAX_DEPTH_BITS'(TOTAL_NUM - 1);

  function automatic logic [BRAM_WIDTH-1:0] sat_inc(input logic [BRAM_WIDTH-1:0] v);
    return (v == {BRAM_WIDTH{1'b1}}) ? v : v + BRAM_WIDTH'(1);
  endfunction

  ddos_state_e               state_q;
  logic [MAX_DEPTH_BITS-1:0] idx_q;
  logic                      host_prio_q;
  logic                      wr_en_q;
  logic [MAX_DEPTH_BITS-1:0] addr_q;
  logic [BRAM_WIDTH-1:0]     wr_data_q;
  logic                      alarm_valid_q;
  logic [MAX_DEPTH_BITS-1:0] alarm_idx_q;
  logic                      ack_q;
  logic [BRAM_WIDTH-1:0]     rdata_q;
  logic                      clear_busy_q;

  logic                      clear_pending;
  logic                      clr_start;
  logic                      host_wins;
  logic [BRAM_WIDTH-1:0]     new_val;
  logic                      crossed;

  assign clr_start = (state_q == IDLE) && clear_pending;
  // Round-robin: host wins when it holds priority or no update competes.
  assign host_wins = host_rd_req && (host_prio_q || !upd_valid);
  assign upd_ready = (state_q == IDLE) && !clear_pending && !(host_rd_req && host_prio_q);

  // With threshold 0 the first term is never true, so no alarms fire.
  assign new_val = sat_inc(bram_rd_data);
  assign crossed = (bram_rd_data < threshold) && (new_val >= threshold);

  ddos_window_timer #(
    .WINDOW_CYCLES (WINDOW_CYCLES)
  ) u_timer (
    .clk             (clk),
    .reset           (reset),
    .sw_clear_i      (sw_clear),
    .clear_busy_i    (clear_busy_q),
    .clr_start_i     (clr_start),
    .clear_pending_o (clear_pending)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      host_prio_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      alarm_valid_q <= 1'b0;
      alarm_idx_q   <= '0;
      ack_q         <= 1'b0;
      rdata_q       <= '0;
      clear_busy_q  <= 1'b0;
    end else begin
      alarm_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_pending) begin
            state_q      <= CLR;
            clear_busy_q <= 1'b1;
            wr_en_q      <= 1'b1;
            wr_data_q    <= '0;
            addr_q       <= '0;
          end else if (host_wins) begin
            state_q     <= H_RD;
            addr_q      <= host_rd_idx;
            host_prio_q <= 1'b0;
          end else if (upd_valid) begin
            state_q     <= U_RD;
            addr_q      <= upd_idx;
            idx_q       <= upd_idx;
            host_prio_q <= 1'b1;
          end
        end
        // Read issued; data arrives next cycle.
        U_RD: state_q <= U_MOD;
        // Read data valid: compute saturated value and crossing.
        U_MOD: begin
          state_q       <= U_WR;
          wr_en_q       <= 1'b1;
          wr_data_q     <= new_val;
          alarm_valid_q <= crossed;
          alarm_idx_q   <= idx_q;
        end
        // Write-back cycle.
        U_WR: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
        end
        H_RD: begin
          state_q <= H_WAIT;
          ack_q   <= 1'b1;
        end
        H_WAIT: begin
          state_q <= IDLE;
          rdata_q <= bram_rd_data;
        end
        CLR: begin
          if (addr_q == LAST_ADDR) begin
            state_q      <= IDLE;
            wr_en_q      <= 1'b0;
            clear_busy_q <= 1'b0;
          end else begin
            addr_q <= addr_q + MAX_DEPTH_BITS'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_wr_en   = wr_en_q;
  assign bram_addr    = addr_q;
  assign bram_wr_data = wr_data_q;
  assign alarm_valid  = alarm_valid_q;
  assign alarm_idx    = alarm_idx_q;
  assign clear_busy   = clear_busy_q;
  assign host_rd_ack  = ack_q;
  // RAM data is only valid in the ack cycle; afterwards the captured copy is held.
  assign host_rd_data = ack_q ? bram_rd_data : rdata_q;

`ifdef DDOS_CTRL_STATS_EN
  logic [31:0] upd_cnt_q, alarm_cnt_q, sat_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_cnt_q   <= '0;
      alarm_cnt_q <= '0;
      sat_cnt_q   <= '0;
    end else begin
      if (upd_valid && upd_ready)                 upd_cnt_q   <= upd_cnt_q + 32'd1;
      if (alarm_valid_q)                          alarm_cnt_q <= alarm_cnt_q + 32'd1;
      if ((state_q == U_MOD) && (&bram_rd_data))  sat_cnt_q   <= sat_cnt_q + 32'd1;
    end
  end

  assign stat_upd_cnt   = upd_cnt_q;
  assign stat_alarm_cnt = alarm_cnt_q;
  assign stat_sat_cnt   = sat_cnt_q;
`endif

endmodule

// File: doc/ddos_counter_ctrl.md
Name: ddos_counter_ctrl

Overview:
Sequencer and arbiter for one single-port per-flow counter RAM (1-cycle registered read; read-during-write returns old data) in the DDoS detection path. Serialises three users onto that RAM port:
- packet-driven read-modify-write increments,
- host register reads,
- periodic whole-table clears at each measurement window.
Raises an alarm the first time an entry crosses a programmable threshold within a window.

Parameters:
BRAM_WIDTH, 37, counter/entry width in bits
MAX_DEPTH_BITS, 14, RAM address width
TOTAL_NUM, 2**MAX_DEPTH_BITS, entries swept by a clear
WINDOW_CYCLES, 125000000, clock cycles per measurement window (1 s at 125 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
upd_valid  in  1  increment request
upd_idx  in  MAX_DEPTH_BITS  entry to increment
upd_ready  out  1  update accepted when upd_valid & upd_ready
host_rd_req  in  1  host read request (level; held until ack)
host_rd_idx  in  MAX_DEPTH_BITS  host read address
host_rd_ack  out  1  1-cycle pulse, host_rd_data valid
host_rd_data  out  BRAM_WIDTH  entry value read
sw_clear  in  1  pulse: request immediate table clear
threshold  in  BRAM_WIDTH  alarm threshold (quasi-static)
alarm_valid  out  1  1-cycle pulse on threshold crossing
alarm_idx  out  MAX_DEPTH_BITS  entry that crossed
clear_busy  out  1  high while a sweep is in progress
bram_wr_en  out  1  RAM write enable
bram_addr  out  MAX_DEPTH_BITS  RAM address
bram_wr_data  out  BRAM_WIDTH  RAM write data
bram_rd_data  in  BRAM_WIDTH  RAM registered read data

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Window counter 0. clear_pending 1, so the table is swept immediately after reset.
- FSM states: IDLE, U_RD, U_MOD, U_WR, H_RD, H_WAIT, CLR.
- IDLE arbitration, first match wins:
  1. clear_pending -> CLR.
  2. Update vs host, round-robin: after an update is served the host wins the next tie, and vice versa. A waiting host read is therefore served after at most one update.
- upd_ready = (state==IDLE) & ~clear_pending & ~(host_rd_req & host_priority). Purely combinational from registered state.
- Update timing, handshake in cycle T:
  - T+1 U_RD: bram_addr=idx (latched), wr_en=0.
  - T+2 U_MOD: new = (rd_data==all-ones) ? rd_data : rd_data+1 (saturating). Register new and crossed = (rd_data<threshold) & (new>=threshold), unsigned.
  - T+3 U_WR: wr_en=1, addr=idx, wr_data=new. alarm_valid=crossed, alarm_idx=idx. IDLE at T+4.
  - Throughput: 1 update per 4 cycles. No hazard forwarding is needed because operations are fully serialised.
- Host read: accepted in IDLE at T. T+1 H_RD drives addr. T+2 H_WAIT: host_rd_ack=1, host_rd_data=rd_data (registered, held until the next ack). Back to IDLE at T+3. The requester drops host_rd_req on ack; a request still high at IDLE is treated as a new read.
- Window: free-running counter 0..WINDOW_CYCLES-1, held at 0 while clear_busy. On reaching WINDOW_CYCLES-1, or on sw_clear, set clear_pending.
  - clear_pending is cleared on entry to CLR.
  - sw_clear during CLR is ignored.
  - An in-flight update or host read always completes before CLR is entered.
- CLR: wr_en=1, wr_data=0, addr steps 0..TOTAL_NUM-1, one per cycle. clear_busy=1 throughout. Enters IDLE after the last address, so the sweep takes TOTAL_NUM cycles. Window counter restarts from 0 on exit.
- Threshold 0: the crossed condition is never true (rd_data<0 is false), so no alarms.
- Only bram_wr_en/bram_addr/bram_wr_data drive the RAM. bram_addr holds its last value when idle; wr_en=0 outside U_WR/CLR.

Optional Feature:
DDOS_CTRL_STATS_EN
- Defined: adds outputs stat_upd_cnt[31:0] (accepted updates), stat_alarm_cnt[31:0] (alarm pulses) and stat_sat_cnt[31:0] (increments blocked by saturation). All are wrapping counters, reset to 0 by reset only, not by window clears.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- Shared package ddos_pkg: FSM state encoding, default widths (BRAM_WIDTH, MAX_DEPTH_BITS), WINDOW_CYCLES default.
- One natural sub-module: ddos_window_timer (window counter, sw_clear merge, clear_pending generation, hold-during-clear).
- The RAM stays external, instantiated beside this block.

Test Plan:
Use MAX_DEPTH_BITS=4, WINDOW_CYCLES=200, BRAM_WIDTH=8 and a behavioural RAM model.
1. Reset released -> clear_busy high exactly 16 cycles, entries 0..15 written 0, upd_ready low until done.
2. Three updates to idx 5 with threshold=3 -> RAM[5]=3; alarm_valid exactly once, alarm_idx=5, on the third update's U_WR cycle; upd_ready spacing 4 cycles.
3. Preload RAM[2]=255, update idx 2 -> value stays 255, no alarm; stat_sat_cnt=1 with DDOS_CTRL_STATS_EN.
4. upd_valid held continuously plus host_rd_req idx 5 -> host ack within one update turn, host_rd_data equals RAM[5] at that point; updates then resume.
5. sw_clear pulsed mid-update U_MOD -> update write completes, then a 16-cycle sweep; subsequent host read of idx 5 returns 0; window restarts (next auto-clear 200 cycles after sweep end).
6. reset asserted during CLR at address 7 -> outputs 0 immediately; after release a full sweep restarts from address 0.
